cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 for the five-stage MIPS pipeline: the receiving end of the fetch stage's exception/interrupt interface. It sits beside the M stage and collects pipelined exception codes (AdEL from fetch and later stages) and hardware interrupt lines. It drives `IntReq` and `EPC` back to the fetch stage, which redirects to the handler at 0x4180 or returns on `eret`. It also services `mfc0`/`mtc0` for registers SR(12), Cause(13), EPC(14) and PRId(15).

## Interface
- `PRID_VAL`, default 32'h0000_0000: constant returned for PRId reads.
- `clk`  in  1  — sole clock; all state updates on rising edge.
- `reset`  in  1  — asynchronous, active-low; clears all CP0 state.
- `A1`  in  5  — `mfc0` read register number.
- `A2`  in  5  — `mtc0` write register number.
- `DIn`  in  32  — `mtc0` write data.
- `WE`  in  1  — `mtc0` write enable.
- `PC_M`  in  32  — PC of the instruction currently in M.
- `BD_M`  in  1  — M instruction sits in a branch delay slot.
- `ExcCode_M`  in  5  — pipelined exception code for M; 0 = none.
- `HWInt`  in  6  — hardware interrupt lines, level-sensitive.
- `eret_M`  in  1  — `eret` in M.
- `IntReq`  out  1  — take exception/interrupt now (combinational).
- `EPC`  out  32  — return address for fetch on `eret`.
- `DOut`  out  32  — `mfc0` read data (combinational).

## Operation
- SR fields: IM = [15:10], EXL = [1], IE = [0]. All other bits read 0.
- Cause fields: BD = [31], IP = [15:10], ExcCode = [6:2]. All other bits read 0.
- `int_pend` = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
- `exc_pend` = (ExcCode_M != 0) & !SR.EXL.
- `IntReq` = `int_pend` | `exc_pend`.
- Priority: interrupt over exception, exception over `eret_M`, `eret_M` over `mtc0`.
- On an edge with `IntReq`=1:
  - SR.EXL ← 1.
  - Cause.BD ← BD_M.
  - Cause.ExcCode ← 0 if `int_pend`, else ExcCode_M.
  - EPC ← BD_M ? PC_M−4 : PC_M, 32-bit wrap, no alignment forcing (a misaligned AdEL PC is kept verbatim).
- On an edge with `eret_M`=1 and `IntReq`=0: SR.EXL ← 0.
- `mtc0` (WE=1, `IntReq`=0):
  - A2=12 writes IM, EXL and IE only.
  - A2=14 writes EPC with all 32 bits.
  - Writes to 13, 15 and any other number are ignored.
- Cause.IP ← HWInt every edge, unconditionally.
- `DOut`: A1 = 12/13/14/15 returns SR/Cause/EPC/PRID_VAL; any other number returns 0.

## Timing
- Reset values: SR=0, Cause=0, EPC=0. Outputs after reset: `IntReq`=0 (IE=0), `EPC`=0, and `DOut` per A1.
- `IntReq` is combinational and asserts in the same cycle as its cause. EXL sets on the following edge, so `IntReq` is a single-cycle pulse unless the handler later clears EXL.
- While EXL=1, all interrupts and exceptions are masked, so no nested capture occurs.
- Cause.IP lags HWInt by one cycle; `int_pend` uses raw HWInt.
- Register effects of `mtc0` are visible on `DOut` the cycle after the edge.
- Reset asserted mid-handler clears EXL immediately (asynchronous); `IntReq` then stays 0 until software sets IE.
- `eret_M` with EXL=0 is harmless: EXL stays 0.

## Configuration
- `CP0_EPC_FWD_EN` defined: `EPC` output = DIn when WE=1 and A2=14 in the same cycle, otherwise the register. This lets `mtc0 EPC` followed immediately by `eret` work without a stall.
- Undefined: `EPC` output is always the register value. The hazard unit must stall `eret` while an `mtc0` to register 14 is in flight.

## Structure
- Package `cp0_pkg` holds:
  - Register numbers SR=12, CAUSE=13, EPC=14, PRID=15.
  - Field bit positions.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - HANDLER_PC = 32'h0000_4180.
- One combinational sub-module, `cp0_req_arb`, computes `int_pend`, `exc_pend`, `IntReq` and the selected ExcCode. The register file lives in `cp0_unit`.

## Test plan
- Reset low, then high; read A1 = 12/13/14: `DOut`=0 each time, `IntReq`=0, PRId returns PRID_VAL.
- `mtc0` SR=32'h0000_0401 (IM[10], IE), then HWInt=6'b000001, PC_M=0x3010, BD_M=0:
  - `IntReq`=1 for exactly one cycle.
  - Afterwards EPC=0x3010, Cause.ExcCode=0, SR.EXL=1.
- IE=0, ExcCode_M=4 (AdEL), PC_M=0x3002, BD_M=1:
  - `IntReq`=1.
  - EPC=0x2FFE, Cause=32'h8000_0010.
- HWInt pending and enabled together with ExcCode_M=12 in the same cycle: Cause.ExcCode=0 (interrupt wins).
- Inside the handler, assert `eret_M`:
  - EXL→0 on the next edge.
  - If HWInt is still active, `IntReq` reasserts the cycle after.
- With `CP0_EPC_FWD_EN` defined, WE=1, A2=14, DIn=0x3400: `EPC` output = 0x3400 in the same cycle. Without the macro, it reads 0x3400 only after the edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants and types for the MIPS coprocessor-0 slice.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_BD_BIT = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  typedef struct packed {
    logic       int_pend;
    logic       exc_pend;
    logic       int_req;
    logic [4:0] exc_code;
  } arb_rsp_t;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w = '0;
    w[SR_IM_HI:SR_IM_LO] = im;
    w[SR_EXL_BIT]        = exl;
    w[SR_IE_BIT]         = ie;
    return w;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD_BIT]                 = bd;
    w[CAUSE_IP_HI:CAUSE_IP_LO]      = ip;
    w[CAUSE_EXC_HI:CAUSE_EXC_LO]    = exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Combinational request arbiter: interrupt beats exception, both masked by EXL.
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code_m,
  output arb_rsp_t   rsp
);

  always_comb begin
    rsp          = '0;
    rsp.int_pend = (|(hw_int & im)) & ie & ~exl;
    rsp.exc_pend = (exc_code_m != EXC_INT) & ~exl;
    rsp.int_req  = rsp.int_pend | rsp.exc_pend;
    rsp.exc_code = rsp.int_pend ? EXC_INT : exc_code_m;
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId, exception capture and mfc0/mtc0 access.
// Optional CP0_EPC_FWD_EN forwards an in-flight mtc0 EPC write to the EPC output.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  input  logic        eret_M,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  arb_rsp_t    arb;

  cp0_req_arb u_arb (
    .hw_int     (HWInt),
    .im         (im_q),
    .ie         (ie_q),
    .exl        (exl_q),
    .exc_code_m (ExcCode_M),
    .rsp        (arb)
  );

  assign IntReq = arb.int_req;

  // Priority: capture > eret > mtc0; IP samples the raw lines every edge.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = HWInt;
    if (arb.int_pend || arb.exc_pend) begin
      exl_d = 1'b1;
      bd_d  = BD_M;
      exc_d = arb.exc_code;
      epc_d = BD_M ? (PC_M - 32'd4) : PC_M;
    end else if (eret_M) begin
      exl_d = 1'b0;
    end else if (WE) begin
      if (A2 == REG_SR) begin
        im_d  = DIn[SR_IM_HI:SR_IM_LO];
        exl_d = DIn[SR_EXL_BIT];
        ie_d  = DIn[SR_IE_BIT];
      end else if (A2 == REG_EPC) begin
        epc_d = DIn;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

`ifdef CP0_EPC_FWD_EN
  assign EPC = (WE && (A2 == REG_EPC)) ? DIn : epc_q;
`else
  assign EPC = epc_q;
`endif

  always_comb begin
    DOut = '0;
    case (A1)
      REG_SR:    DOut = pack_sr(im_q, exl_q, ie_q);
      REG_CAUSE: DOut = pack_cause(bd_q, ip_q, exc_q);
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID_VAL;
      default:   DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized traffic
// against a word-level register model.
`timescale 1ns/1ps
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0001_9300;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCode_M;
  logic [31:0] DIn, PC_M;
  logic        WE, BD_M, eret_M;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] EPC, DOut;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_sr, m_cause, m_epc;

  cp0_unit #(.PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC_M(PC_M), .BD_M(BD_M), .ExcCode_M(ExcCode_M), .HWInt(HWInt),
    .eret_M(eret_M), .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  always #10 clk = ~clk;

  task automatic idle();
    A1 = 5'd0; A2 = 5'd0; DIn = '0; WE = 1'b0; PC_M = '0; BD_M = 1'b0;
    ExcCode_M = '0; HWInt = '0; eret_M = 1'b0;
  endtask

  task automatic model_reset();
    m_sr = '0; m_cause = '0; m_epc = '0;
  endtask

  // Checks the combinational outputs against the model, clocks once, updates the model.
  task automatic cycle_check(input string tag);
    logic ip, ep, req;
    logic [31:0] e_epc, e_dout;
    #1;
    ip  = ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    ep  = (ExcCode_M != 5'd0) && !m_sr[1];
    req = ip || ep;
    e_epc = m_epc;
`ifdef CP0_EPC_FWD_EN
    if (WE && A2 == 5'd14) e_epc = DIn;
`endif
    case (A1)
      5'd12:   e_dout = m_sr;
      5'd13:   e_dout = m_cause;
      5'd14:   e_dout = m_epc;
      5'd15:   e_dout = PRID;
      default: e_dout = 32'h0;
    endcase
    checks++;
    if (IntReq !== req) begin
      errors++; $display("FAIL %s IntReq got %b want %b", tag, IntReq, req);
    end
    checks++;
    if (EPC !== e_epc) begin
      errors++; $display("FAIL %s EPC got %h want %h", tag, EPC, e_epc);
    end
    checks++;
    if (DOut !== e_dout) begin
      errors++; $display("FAIL %s DOut(A1=%0d) got %h want %h", tag, A1, DOut, e_dout);
    end
    @(posedge clk);
    if (req) begin
      m_sr    = m_sr | 32'h2;
      m_cause = (BD_M ? 32'h8000_0000 : 32'h0) | ({27'd0, (ip ? 5'd0 : ExcCode_M)} << 2);
      m_epc   = BD_M ? PC_M - 32'd4 : PC_M;
    end else if (eret_M) begin
      m_sr = m_sr & ~32'h2;
    end else if (WE) begin
      if (A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
      else if (A2 == 5'd14) m_epc = DIn;
    end
    m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] want;
    reset = 1'b0;
    idle();
    model_reset();
    #3;
    for (int r = 12; r <= 15; r++) begin
      A1 = 5'(r);
      #1;
      want = (r == 15) ? PRID : 32'h0;
      checks++;
      if (DOut !== want) begin
        errors++; $display("FAIL reset_dout A1=%0d got %h want %h", r, DOut, want);
      end
    end
    checks++;
    if (IntReq !== 1'b0 || EPC !== 32'h0) begin
      errors++; $display("FAIL reset_out IntReq=%b EPC=%h want 0/0", IntReq, EPC);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_interrupt();
    idle();
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    cycle_check("int_mtc0_sr");
    WE = 1'b0; HWInt = 6'b000001; PC_M = 32'h3010; BD_M = 1'b0;
    #1;
    checks++;
    if (IntReq !== 1'b1) begin
      errors++; $display("FAIL int_assert IntReq got %b want 1", IntReq);
    end
    cycle_check("int_take");
    checks++;
    if (IntReq !== 1'b0) begin
      errors++; $display("FAIL int_pulse IntReq got %b want 0", IntReq);
    end
    A1 = 5'd14; #1;
    checks++;
    if (DOut !== 32'h3010) begin
      errors++; $display("FAIL int_epc got %h want 00003010", DOut);
    end
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h0000_0400) begin
      errors++; $display("FAIL int_cause got %h want 00000400", DOut);
    end
    A1 = 5'd12; #1;
    checks++;
    if (DOut !== 32'h0000_0403) begin
      errors++; $display("FAIL int_sr got %h want 00000403", DOut);
    end
    cycle_check("int_hold");
  endtask

  task automatic test_eret();
    eret_M = 1'b1; A1 = 5'd12;
    cycle_check("eret");
    eret_M = 1'b0;
    #1;
    checks++;
    if (DOut !== 32'h0000_0401) begin
      errors++; $display("FAIL eret_sr got %h want 00000401", DOut);
    end
    checks++;
    if (IntReq !== 1'b1) begin
      errors++; $display("FAIL eret_reassert IntReq got %b want 1", IntReq);
    end
    cycle_check("eret_retake");
    eret_M = 1'b1; HWInt = 6'd0;
    cycle_check("eret_leave");
    eret_M = 1'b1;
    cycle_check("eret_harmless");
    eret_M = 1'b0;
  endtask

  task automatic test_exception();
    idle();
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0;
    cycle_check("exc_clear_sr");
    WE = 1'b0; ExcCode_M = 5'd4; PC_M = 32'h3002; BD_M = 1'b1;
    #1;
    checks++;
    if (IntReq !== 1'b1) begin
      errors++; $display("FAIL exc_assert IntReq got %b want 1", IntReq);
    end
    cycle_check("exc_take");
    ExcCode_M = 5'd0; BD_M = 1'b0;
    A1 = 5'd14; #1;
    checks++;
    if (DOut !== 32'h0000_2FFE) begin
      errors++; $display("FAIL exc_epc got %h want 00002ffe", DOut);
    end
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h8000_0010) begin
      errors++; $display("FAIL exc_cause got %h want 80000010", DOut);
    end
    cycle_check("exc_hold");
  endtask

  task automatic test_priority();
    idle();
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    cycle_check("prio_mtc0_sr");
    WE = 1'b0; HWInt = 6'b000001; ExcCode_M = 5'd12; PC_M = 32'h3100;
    cycle_check("prio_take");
    ExcCode_M = 5'd0; A1 = 5'd13; #1;
    checks++;
    if (DOut[6:2] !== 5'd0) begin
      errors++; $display("FAIL prio_exccode got %0d want 0", DOut[6:2]);
    end
    cycle_check("prio_hold");
  endtask

  task automatic test_epc_fwd();
    logic [31:0] want;
    WE = 1'b1; A2 = 5'd14; DIn = 32'h3400; A1 = 5'd14;
    #1;
`ifdef CP0_EPC_FWD_EN
    want = 32'h3400;
`else
    want = m_epc;
`endif
    checks++;
    if (EPC !== want) begin
      errors++; $display("FAIL epc_same_cycle got %h want %h", EPC, want);
    end
    cycle_check("epc_write");
    WE = 1'b0; #1;
    checks++;
    if (EPC !== 32'h3400) begin
      errors++; $display("FAIL epc_after_edge got %h want 00003400", EPC);
    end
  endtask

  task automatic test_reset_mid_handler();
    idle();
    HWInt = 6'b100000; A1 = 5'd12;
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (DOut !== 32'h0 || IntReq !== 1'b0 || EPC !== 32'h0) begin
      errors++; $display("FAIL reset_mid DOut=%h IntReq=%b EPC=%h want 0/0/0", DOut, IntReq, EPC);
    end
    #3;
    reset = 1'b1;
    cycle_check("reset_mid_a");
    cycle_check("reset_mid_b");
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 5));
      A1 = (sel < 4) ? 5'(12 + sel) : 5'($urandom);
      sel = int'($urandom_range(0, 5));
      A2 = (sel < 4) ? 5'(12 + sel) : 5'($urandom);
      DIn       = $urandom;
      WE        = ($urandom_range(0, 2) == 0);
      PC_M      = $urandom;
      BD_M      = 1'($urandom);
      ExcCode_M = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      HWInt     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      eret_M    = ($urandom_range(0, 3) == 0);
      cycle_check("random");
    end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_eret();
    test_exception();
    test_priority();
    test_epc_fwd();
    test_reset_mid_handler();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
